mul_div_unit: RTL and testbench
===============================

Name: mul_div_unit

Overview:
- Execution unit directly downstream of a reservation_station instantiated with the MUL/DIV instruction type.
- Consumes the station's registered operand/instruction outputs and pulses `next` to pop the entry.
- Performs RV32M multiply (2-cycle) and iterative divide/remainder, then arbitrates for one common data bus slot to broadcast result and rrn.
- Honours speculative tag kill (`delete_tag`) and tag resolution (`clear_tag`).

Parameters:
- DIV_BITS, 1, quotient bits retired per divide iteration; legal values 1, 2, 4; iterations = 32/DIV_BITS.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- delete_tag  in  1  kill any in-flight op whose tag bit is set
- clear_tag  in  1  speculation resolved; clear the held tag bit
- i_data_1  in  32  rs1 operand from reservation station
- i_data_2  in  32  rs2 operand from reservation station
- i_instr_name  in  instr_name_e  op; UNKNOWN = no valid entry
- i_rrn  in  6  destination rename register
- i_tag  in  1  speculative tag of the presented entry
- next  out  1  pop strobe to reservation station (combinational)
- busy  out  1  state != IDLE
- o_cdb_request  out  1  request data bus slot
- i_cdb_grant  in  1  slot granted this cycle
- o_result  out  32  result to data bus
- o_rrn  out  6  rename tag to data bus

Behaviour:
- Reset (reset==0, async): state=IDLE; next=0; busy=0; o_cdb_request=0; o_result=0; o_rrn=0; held tag=0; iteration counter=0.
- States: IDLE, MUL, DIV, FIX, DONE.
- Accept (IDLE):
  - Accept when i_instr_name ∈ {MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU} and !(delete_tag && i_tag).
  - next=1 in that same cycle only; latch operands, op, rrn, tag.
  - Any other name, including UNKNOWN: stay IDLE, next=0.
- MUL:
  - One cycle. 33x33 signed product using operand sign-extension per op (MULHSU: rs1 signed, rs2 unsigned).
  - MUL takes bits [31:0]; all MULH variants take bits [63:32]. Register the result, go to DONE.
  - o_cdb_request rises at accept+2.
- DIV entry:
  - Divisor==0: quotient=0xFFFFFFFF, remainder=dividend.
  - Signed overflow (0x80000000 / 0xFFFFFFFF, DIV/REM): quotient=0x80000000, remainder=0.
  - Both cases go straight to DONE; request at accept+2.
  - Otherwise take absolute values (signed ops) and enter DIV.
- DIV:
  - Restoring division, DIV_BITS quotient bits per cycle, counter counts 32/DIV_BITS cycles.
  - Then FIX (1 cycle): quotient negated if operand signs differ; remainder takes the dividend's sign.
  - Then DONE. Default request at accept+34.
- DONE:
  - o_cdb_request=1 with o_result/o_rrn stable until a cycle with i_cdb_grant=1.
  - That cycle is the broadcast. Next cycle: IDLE, request=0.
  - No accept in the grant cycle.
- Grant while request=0: ignored.
- delete_tag:
  - Held tag=1 and state≠IDLE: go to IDLE next cycle; request drops; no broadcast. This applies in DONE even if i_cdb_grant is high in the same cycle (kill wins).
  - Held tag=0: unaffected.
- clear_tag: clears the held tag. If clear_tag and delete_tag are asserted in the same cycle, delete_tag wins.
- Arithmetic: all 32-bit, two's complement; wrap permitted in MUL low word.
- Reset mid-op: immediate return to IDLE; no broadcast; entry is lost (the station is reset together with this unit).

Decomposition:
- pkg_structures:
  - Add MUL..REMU to instr_name_e if absent.
  - Add muldiv_state_e {IDLE, MUL, DIV, FIX, DONE}.
  - Add a MULDIV instr_type_e value.
- Sub-module iterative_divider:
  - Unsigned, parameter DIV_BITS.
  - Ports: start, dividend, divisor, done, quotient, remainder.
  - Sign handling, special cases and FSM stay in mul_div_unit.

Test Plan:
- MUL 7 x -3 (0x00000007, 0xFFFFFFFD), rrn=5, grant held high → next pulse at cycle 0; request at cycle 2 with o_result=0xFFFFFFEB, o_rrn=5; IDLE at cycle 3.
- MULHU 0xFFFFFFFF x 0xFFFFFFFF → 0xFFFFFFFE. MULH of the same operands → 0x00000000. MULHSU 0xFFFFFFFF x 0x00000002 → 0xFFFFFFFF.
- DIV -20/3 → 0xFFFFFFFA; REM -20/3 → 0xFFFFFFFE; request exactly at accept+34 (DIV_BITS=1) and accept+18 (DIV_BITS=2).
- DIVU 100/0 → 0xFFFFFFFF and REMU 100/0 → 100; DIV 0x80000000/0xFFFFFFFF → 0x80000000 and REM → 0; all at accept+2.
- Tagged DIV accepted, delete_tag at accept+10 → no request ever, IDLE at accept+11. Repeat with clear_tag at accept+5 → completes normally.
- Hold i_cdb_grant=0 for 5 cycles in DONE with a second valid entry presented → request and result stable, next stays 0. Grant → broadcast; second entry accepted the cycle after. Async reset asserted mid-DIV → all outputs 0 immediately.

Source files
------------

// File: rtl/mul_div_unit_pkg.sv
// mul_div_unit_pkg: shared enums and op-decode helpers for the multiply/divide unit
package mul_div_unit_pkg;
  typedef enum logic [4:0] {
    UNKNOWN, ADD, SUB, SLT, LW, SW, BEQ, BNE, JAL,
    MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
  } instr_name_e;
  typedef enum logic [1:0] {T_ARITH, T_MEM, T_BRANCH, MULDIV} instr_type_e;
  typedef enum logic [2:0] {ST_IDLE, ST_MUL, ST_DIV, ST_FIX, ST_DONE} muldiv_state_e;
  function automatic logic is_muldiv(instr_name_e n);
    return n inside {MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU};
  endfunction
  function automatic logic is_div(instr_name_e n);
    return n inside {DIV, DIVU, REM, REMU};
  endfunction
  function automatic logic is_signed_div(instr_name_e n);
    return n inside {DIV, REM};
  endfunction
endpackage

// File: rtl/mul_div_unit_iterative_divider.sv
// iterative_divider: unsigned restoring divider retiring DIV_BITS quotient bits per cycle
module iterative_divider #(
  parameter int DIV_BITS = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);
  localparam int ITER = 32 / DIV_BITS;
  localparam int CW = $clog2(ITER + 1);
  logic [31:0] q_q, q_d, r_q, r_d, d_q, d_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [32:0] t;
  // load on start, otherwise shift/subtract DIV_BITS times while iterations remain
  always_comb begin
    q_d = q_q;
    r_d = r_q;
    d_d = d_q;
    cnt_d = cnt_q;
    t = '0;
    if (start) begin
      q_d = dividend;
      r_d = '0;
      d_d = divisor;
      cnt_d = CW'(ITER);
    end else if (cnt_q != '0) begin
      for (int i = 0; i < DIV_BITS; i++) begin
        t = {r_d, q_d[31]};
        q_d = {q_d[30:0], 1'b0};
        if (t >= {1'b0, d_d}) begin
          t = t - {1'b0, d_d};
          q_d[0] = 1'b1;
        end
        r_d = t[31:0];
      end
      cnt_d = cnt_q - CW'(1);
    end
  end
  // iteration state registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      q_q <= '0;
      r_q <= '0;
      d_q <= '0;
      cnt_q <= '0;
    end else begin
      q_q <= q_d;
      r_q <= r_d;
      d_q <= d_d;
      cnt_q <= cnt_d;
    end
  end
  // done flags the final iteration; quotient/remainder are valid the following cycle
  assign done = cnt_q == CW'(1);
  assign quotient = q_q;
  assign remainder = r_q;
endmodule

// File: rtl/mul_div_unit.sv
// mul_div_unit: RV32M multiply/divide execution unit with speculative kill and data-bus handshake
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int DIV_BITS = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        delete_tag,
  input  logic        clear_tag,
  input  logic [31:0] i_data_1,
  input  logic [31:0] i_data_2,
  input  instr_name_e i_instr_name,
  input  logic [5:0]  i_rrn,
  input  logic        i_tag,
  output logic        next,
  output logic        busy,
  output logic        o_cdb_request,
  input  logic        i_cdb_grant,
  output logic [31:0] o_result,
  output logic [5:0]  o_rrn
);
  muldiv_state_e state_q, state_d;
  instr_name_e op_q, op_d;
  logic [31:0] a_q, a_d, b_q, b_d, result_q, result_d;
  logic [5:0] rrn_q, rrn_d;
  logic tag_q, tag_d;
  logic accept, kill, div_done, sgn, is_rem, special;
  logic [31:0] quo, rem, dvd, dvs, special_res, fix_res, mul_res;
  logic signed [32:0] mx, my;
  logic signed [65:0] prod;
  assign accept = reset && state_q == ST_IDLE && is_muldiv(i_instr_name) && !(delete_tag && i_tag);
  assign kill = delete_tag && tag_q && state_q != ST_IDLE;
  assign dvd = (is_signed_div(i_instr_name) && i_data_1[31]) ? -i_data_1 : i_data_1;
  assign dvs = (is_signed_div(i_instr_name) && i_data_2[31]) ? -i_data_2 : i_data_2;
  iterative_divider #(.DIV_BITS(DIV_BITS)) u_div (
    .clock(clock), .reset(reset), .start(accept && is_div(i_instr_name)),
    .dividend(dvd), .divisor(dvs), .done(div_done), .quotient(quo), .remainder(rem)
  );
  assign sgn = is_signed_div(op_q);
  assign is_rem = op_q inside {REM, REMU};
  assign special = b_q == '0 || (sgn && a_q == 32'h8000_0000 && b_q == 32'hFFFF_FFFF);
  assign special_res = b_q == '0 ? (is_rem ? a_q : '1) : (is_rem ? '0 : 32'h8000_0000);
  assign fix_res = is_rem ? ((sgn && a_q[31]) ? -rem : rem) : ((sgn && (a_q[31] ^ b_q[31])) ? -quo : quo);
  assign mx = {(op_q inside {MULH, MULHSU}) & a_q[31], a_q};
  assign my = {(op_q == MULH) & b_q[31], b_q};
  assign prod = 66'(mx) * 66'(my);
  assign mul_res = op_q == MUL ? prod[31:0] : prod[63:32];
  // state and datapath registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      op_q <= UNKNOWN;
      a_q <= '0;
      b_q <= '0;
      rrn_q <= '0;
      tag_q <= 1'b0;
      result_q <= '0;
    end else begin
      state_q <= state_d;
      op_q <= op_d;
      a_q <= a_d;
      b_q <= b_d;
      rrn_q <= rrn_d;
      tag_q <= tag_d;
      result_q <= result_d;
    end
  end
  // next state; a kill of a tagged op overrides everything, including a grant
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: state_d = accept ? (is_div(i_instr_name) ? ST_DIV : ST_MUL) : ST_IDLE;
      ST_MUL:  state_d = ST_DONE;
      ST_DIV:  state_d = special ? ST_DONE : (div_done ? ST_FIX : ST_DIV);
      ST_FIX:  state_d = ST_DONE;
      ST_DONE: state_d = i_cdb_grant ? ST_IDLE : ST_DONE;
      default: state_d = ST_IDLE;
    endcase
    if (kill) state_d = ST_IDLE;
  end
  // latch the entry on accept and capture results in MUL, special-case DIV and FIX
  always_comb begin
    op_d = op_q;
    a_d = a_q;
    b_d = b_q;
    rrn_d = rrn_q;
    tag_d = clear_tag ? 1'b0 : tag_q;
    result_d = result_q;
    if (accept) begin
      op_d = i_instr_name;
      a_d = i_data_1;
      b_d = i_data_2;
      rrn_d = i_rrn;
      tag_d = i_tag;
    end
    if (state_q == ST_MUL) result_d = mul_res;
    if (state_q == ST_DIV && special) result_d = special_res;
    if (state_q == ST_FIX) result_d = fix_res;
  end
  // handshake outputs
  always_comb begin
    next = accept;
    busy = state_q != ST_IDLE;
    o_cdb_request = state_q == ST_DONE && !kill;
  end
  assign o_result = result_q;
  assign o_rrn = rrn_q;
endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed self-checking bench for mul_div_unit with DIV_BITS=1 and DIV_BITS=2
module tb_mul_div_unit;
  import mul_div_unit_pkg::*;
  logic clock = 1'b0, reset = 1'b0, delete_tag = 1'b0, clear_tag = 1'b0;
  logic [31:0] i_data_1 = '0, i_data_2 = '0;
  instr_name_e i_instr_name = UNKNOWN;
  logic [5:0] i_rrn = '0;
  logic i_tag = 1'b0, i_cdb_grant = 1'b1;
  logic next1, busy1, req1, next2, busy2, req2;
  logic [31:0] res1, res2;
  logic [5:0] rrn1, rrn2;
  int n_cmp = 0, n_bad = 0;
  logic saw;
  mul_div_unit #(.DIV_BITS(1)) dut1 (
    .clock(clock), .reset(reset), .delete_tag(delete_tag), .clear_tag(clear_tag),
    .i_data_1(i_data_1), .i_data_2(i_data_2), .i_instr_name(i_instr_name), .i_rrn(i_rrn),
    .i_tag(i_tag), .next(next1), .busy(busy1), .o_cdb_request(req1), .i_cdb_grant(i_cdb_grant),
    .o_result(res1), .o_rrn(rrn1)
  );
  mul_div_unit #(.DIV_BITS(2)) dut2 (
    .clock(clock), .reset(reset), .delete_tag(delete_tag), .clear_tag(clear_tag),
    .i_data_1(i_data_1), .i_data_2(i_data_2), .i_instr_name(i_instr_name), .i_rrn(i_rrn),
    .i_tag(i_tag), .next(next2), .busy(busy2), .o_cdb_request(req2), .i_cdb_grant(i_cdb_grant),
    .o_result(res2), .o_rrn(rrn2)
  );
  always #5 clock = ~clock;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic present(input instr_name_e op, input logic [31:0] a, input logic [31:0] b,
                         input logic [5:0] rrn, input logic tag);
    @(posedge clock);
    #1;
    i_instr_name = op;
    i_data_1 = a;
    i_data_2 = b;
    i_rrn = rrn;
    i_tag = tag;
  endtask
  task automatic run_op(input string tag, input instr_name_e op, input logic [31:0] a,
                        input logic [31:0] b, input logic [5:0] rrn, input logic [31:0] exp,
                        input int lat1, input int lat2);
    present(op, a, b, rrn, 1'b0);
    @(negedge clock);
    chk({tag, ".next"}, 32'(next1), 32'd1);
    @(posedge clock);
    #1;
    i_instr_name = UNKNOWN;
    for (int c = 1; c <= lat1 + 1; c++) begin
      @(negedge clock);
      if (c == lat1 - 1) chk({tag, ".early_req"}, 32'(req1), 32'd0);
      if (c == lat1) begin
        chk({tag, ".req"}, 32'(req1), 32'd1);
        chk({tag, ".result"}, res1, exp);
        chk({tag, ".rrn"}, 32'(rrn1), 32'(rrn));
      end
      if (c == lat1 + 1) chk({tag, ".idle"}, 32'(busy1), 32'd0);
      if (c == lat2 - 1) chk({tag, ".early_req2"}, 32'(req2), 32'd0);
      if (c == lat2) begin
        chk({tag, ".req2"}, 32'(req2), 32'd1);
        chk({tag, ".result2"}, res2, exp);
      end
    end
  endtask
  initial begin
    #2;
    i_instr_name = MUL;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst.busy", 32'(busy1), 32'd0);
    chk("rst.next", 32'(next1), 32'd0);
    chk("rst.req", 32'(req1), 32'd0);
    chk("rst.result", res1, 32'd0);
    chk("rst.rrn", 32'(rrn1), 32'd0);
    i_instr_name = UNKNOWN;
    reset = 1'b1;
    run_op("mul", MUL, 32'd7, 32'hFFFF_FFFD, 6'd5, 32'hFFFF_FFEB, 2, 2);
    run_op("mulhu", MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd6, 32'hFFFF_FFFE, 2, 2);
    run_op("mulh", MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd7, 32'h0000_0000, 2, 2);
    run_op("mulhsu", MULHSU, 32'hFFFF_FFFF, 32'd2, 6'd8, 32'hFFFF_FFFF, 2, 2);
    run_op("div", DIV, 32'hFFFF_FFEC, 32'd3, 6'd9, 32'hFFFF_FFFA, 34, 18);
    run_op("rem", REM, 32'hFFFF_FFEC, 32'd3, 6'd10, 32'hFFFF_FFFE, 34, 18);
    run_op("div_negb", DIV, 32'd20, 32'hFFFF_FFFD, 6'd11, 32'hFFFF_FFFA, 34, 18);
    run_op("rem_negb", REM, 32'd20, 32'hFFFF_FFFD, 6'd12, 32'd2, 34, 18);
    run_op("divu", DIVU, 32'hFFFF_FFFF, 32'h10, 6'd13, 32'h0FFF_FFFF, 34, 18);
    run_op("remu", REMU, 32'hFFFF_FFFF, 32'h10, 6'd14, 32'hF, 34, 18);
    run_op("divu0", DIVU, 32'd100, 32'd0, 6'd15, 32'hFFFF_FFFF, 2, 2);
    run_op("remu0", REMU, 32'd100, 32'd0, 6'd16, 32'd100, 2, 2);
    run_op("div_ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 6'd17, 32'h8000_0000, 2, 2);
    run_op("rem_ovf", REM, 32'h8000_0000, 32'hFFFF_FFFF, 6'd18, 32'd0, 2, 2);
    present(DIV, 32'hFFFF_FFEC, 32'd3, 6'd20, 1'b1);
    @(negedge clock);
    chk("kill.next", 32'(next1), 32'd1);
    @(posedge clock);
    #1;
    i_instr_name = UNKNOWN;
    i_tag = 1'b0;
    saw = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (c > 1) begin
        @(posedge clock);
        #1;
      end
      delete_tag = (c == 10);
      @(negedge clock);
      if (req1 || req2) saw = 1'b1;
      if (c == 10) chk("kill.busy_before", 32'(busy1), 32'd1);
      if (c == 11) begin
        chk("kill.idle1", 32'(busy1), 32'd0);
        chk("kill.idle2", 32'(busy2), 32'd0);
      end
    end
    chk("kill.no_req", 32'(saw), 32'd0);
    present(DIV, 32'hFFFF_FFEC, 32'd3, 6'd21, 1'b1);
    @(negedge clock);
    chk("clr.next", 32'(next1), 32'd1);
    @(posedge clock);
    #1;
    i_instr_name = UNKNOWN;
    i_tag = 1'b0;
    for (int c = 1; c <= 35; c++) begin
      if (c > 1) begin
        @(posedge clock);
        #1;
      end
      clear_tag = (c == 5);
      delete_tag = (c == 10);
      @(negedge clock);
      if (c == 18) chk("clr.req2", 32'(req2), 32'd1);
      if (c == 33) chk("clr.early_req", 32'(req1), 32'd0);
      if (c == 34) begin
        chk("clr.req", 32'(req1), 32'd1);
        chk("clr.result", res1, 32'hFFFF_FFFA);
        chk("clr.rrn", 32'(rrn1), 32'd21);
      end
      if (c == 35) chk("clr.idle", 32'(busy1), 32'd0);
    end
    present(MUL, 32'd7, 32'hFFFF_FFFD, 6'd5, 1'b0);
    i_cdb_grant = 1'b0;
    @(negedge clock);
    chk("stall.next0", 32'(next1), 32'd1);
    @(posedge clock);
    #1;
    i_instr_name = UNKNOWN;
    for (int c = 2; c <= 8; c++) begin
      @(posedge clock);
      #1;
      if (c == 2) begin
        i_instr_name = MULHU;
        i_data_1 = 32'hFFFF_FFFF;
        i_data_2 = 32'hFFFF_FFFF;
        i_rrn = 6'd12;
      end
      i_cdb_grant = (c >= 7);
      @(negedge clock);
      if (c <= 7) begin
        chk($sformatf("stall.req_c%0d", c), 32'(req1), 32'd1);
        chk($sformatf("stall.result_c%0d", c), res1, 32'hFFFF_FFEB);
        chk($sformatf("stall.rrn_c%0d", c), 32'(rrn1), 32'd5);
        chk($sformatf("stall.next_c%0d", c), 32'(next1), 32'd0);
      end else begin
        chk("stall.req_after", 32'(req1), 32'd0);
        chk("stall.accept2", 32'(next1), 32'd1);
      end
    end
    @(posedge clock);
    #1;
    i_instr_name = UNKNOWN;
    @(negedge clock);
    @(negedge clock);
    chk("stall2.req", 32'(req1), 32'd1);
    chk("stall2.result", res1, 32'hFFFF_FFFE);
    chk("stall2.rrn", 32'(rrn1), 32'd12);
    @(negedge clock);
    chk("stall2.idle", 32'(busy1), 32'd0);
    present(DIVU, 32'd1000, 32'd7, 6'd3, 1'b0);
    @(posedge clock);
    #1;
    i_instr_name = UNKNOWN;
    repeat (9) @(posedge clock);
    @(negedge clock);
    chk("arst.busy_before", 32'(busy1), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("arst.busy", 32'(busy1), 32'd0);
    chk("arst.req", 32'(req1), 32'd0);
    chk("arst.result", res1, 32'd0);
    chk("arst.rrn", 32'(rrn1), 32'd0);
    chk("arst.next", 32'(next1), 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b1;
    repeat (3) @(negedge clock);
    chk("arst.stays_idle", 32'(busy1), 32'd0);
    chk("arst.no_req", 32'(req1), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
